// File: rtl/regfile_sb.sv
// MIPS general-purpose register file with write-to-read bypass and a per-register
// busy scoreboard that issue reserves, writeback releases and flush clears.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter bit BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_1,
    input  logic [ADDR_W-1:0] raddr_2,
    output logic [DATA_W-1:0] rdata_1,
    output logic [DATA_W-1:0] rdata_2,
    output logic              rbusy_1,
    output logic              rbusy_2,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic              rsv_ok,
    input  logic              flush,
    output logic [ADDR_W:0]   busy_cnt
);
    localparam int                NREGS   = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A  = {ADDR_W{1'b0}};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [ADDR_W:0]   cnt_q;
    logic [ADDR_W:0]   cnt_d;
    logic              wr_s;
    logic              set_s;
    logic              inc_s;
    logic              dec_s;

    assign wr_s     = we && (waddr != ZERO_A);
    assign set_s    = rsv_ok && (rsv_addr != ZERO_A);
    assign busy_cnt = cnt_q;

    // Reservation acceptance; a busy register being released this cycle may be re-reserved.
    always_comb begin
        if (rsv_en && !flush) begin
            if (rsv_addr == ZERO_A) begin
                rsv_ok = 1'b1;
            end else if (!busy_q[rsv_addr]) begin
                rsv_ok = 1'b1;
            end else if (we && (waddr == rsv_addr)) begin
                rsv_ok = 1'b1;
            end else begin
                rsv_ok = 1'b0;
            end
        end else begin
            rsv_ok = 1'b0;
        end
    end

    // Read port 1: zero register, then same-cycle writeback, then stored state.
    always_comb begin
        if (raddr_1 == ZERO_A) begin
            rdata_1 = {DATA_W{1'b0}};
            rbusy_1 = 1'b0;
        end else if (we && (waddr == raddr_1)) begin
            rdata_1 = BYPASS ? wdata : regs_q[raddr_1];
            rbusy_1 = 1'b0;
        end else begin
            rdata_1 = regs_q[raddr_1];
            rbusy_1 = busy_q[raddr_1];
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        if (raddr_2 == ZERO_A) begin
            rdata_2 = {DATA_W{1'b0}};
            rbusy_2 = 1'b0;
        end else if (we && (waddr == raddr_2)) begin
            rdata_2 = BYPASS ? wdata : regs_q[raddr_2];
            rbusy_2 = 1'b0;
        end else begin
            rdata_2 = regs_q[raddr_2];
            rbusy_2 = busy_q[raddr_2];
        end
    end

    // Next busy vector: flush beats reserve, reserve beats release of the same register.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            if (flush || (i == 0)) begin
                busy_d[i] = 1'b0;
            end else if (set_s && (rsv_addr == ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (wr_s && (waddr == ADDR_W'(i))) begin
                busy_d[i] = 1'b0;
            end else begin
                busy_d[i] = busy_q[i];
            end
        end
    end

    assign inc_s = set_s && !busy_q[rsv_addr];
    assign dec_s = wr_s && busy_q[waddr] && !(set_s && (rsv_addr == waddr));

    // Busy counter tracks the population of the busy vector incrementally.
    always_comb begin
        if (flush) begin
            cnt_d = {(ADDR_W+1){1'b0}};
        end else if (inc_s && !dec_s) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (dec_s && !inc_s) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Scoreboard state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= {NREGS{1'b0}};
            cnt_q  <= {(ADDR_W+1){1'b0}};
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    // Register storage; register 0 is never written and stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_s) begin
            regs_q[waddr] <= wdata;
        end
    end
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: one bypassing and one non-bypassing instance share stimulus
// and are compared against an array-based reference model.
module tb_regfile_sb;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 32;

    logic          clk = 1'b0;
    logic          rst_n, we, rsv_en, flush;
    logic [AW-1:0] waddr, raddr_1, raddr_2, rsv_addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic          rb1_a, rb2_a, rb1_b, rb2_b, ok_a, ok_b;
    logic [AW:0]   cnt_a, cnt_b;

    logic [DW-1:0] m_regs [NR];
    bit            m_busy [NR];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_1(raddr_1), .raddr_2(raddr_2), .rdata_1(rd1_a), .rdata_2(rd2_a),
        .rbusy_1(rb1_a), .rbusy_2(rb2_a), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_ok(ok_a), .flush(flush), .busy_cnt(cnt_a));

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_1(raddr_1), .raddr_2(raddr_2), .rdata_1(rd1_b), .rdata_2(rd2_b),
        .rbusy_1(rb1_b), .rbusy_2(rb2_b), .rsv_en(rsv_en), .rsv_addr(rsv_addr),
        .rsv_ok(ok_b), .flush(flush), .busy_cnt(cnt_b));

    function automatic logic [DW-1:0] exp_rdata(input logic [AW-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && we && waddr == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic logic exp_rbusy(input logic [AW-1:0] a);
        if (a == 0) return 1'b0;
        if (we && waddr == a) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic exp_ok();
        if (!rsv_en || flush) return 1'b0;
        if (rsv_addr == 0 || !m_busy[rsv_addr]) return 1'b1;
        return we && (waddr == rsv_addr);
    endfunction

    function automatic logic [AW:0] exp_cnt();
        int n = 0;
        for (int i = 0; i < NR; i++) n += int'(m_busy[i]);
        return (AW+1)'(n);
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NR; i++) begin
            m_regs[i] = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0; rsv_en = 1'b0; rsv_addr = '0;
        flush = 1'b0; raddr_1 = '0; raddr_2 = '0;
    endtask

    // Advance one clock edge and apply the architectural rules to the model.
    task automatic tick();
        bit            ok, c_we, c_fl;
        logic [AW-1:0] c_wa, c_ra;
        logic [DW-1:0] c_wd;
        ok = exp_ok(); c_we = we; c_fl = flush; c_wa = waddr; c_ra = rsv_addr; c_wd = wdata;
        @(posedge clk);
        if (c_we && c_wa != 0) begin
            m_regs[c_wa] = c_wd;
            m_busy[c_wa] = 1'b0;
        end
        if (c_fl) begin
            for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
        end else if (ok && c_ra != 0) begin
            m_busy[c_ra] = 1'b1;
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            we = 1'b1; waddr = AW'($urandom_range(1, NR-1)); wdata = $urandom();
            rsv_en = 1'b1; rsv_addr = AW'($urandom_range(1, NR-1));
            #1; tick();
        end
        idle(); raddr_1 = waddr; rsv_en = 1'b1; rsv_addr = 5'd3;
        #2; rst_n = 1'b0; #1; model_clear();
        checks++; if (cnt_a !== 6'd0) begin errors++; $display("FAIL reset_cnt got %0d exp 0", cnt_a); end
        checks++; if (ok_a !== 1'b1) begin errors++; $display("FAIL reset_rsv_ok got %b exp 1", ok_a); end
        for (int i = 1; i < NR; i++) begin
            raddr_1 = AW'(i); raddr_2 = AW'(NR - i); #1;
            checks++; if (rd1_a !== 32'h0 || rd2_b !== 32'h0 || rb1_a !== 1'b0)
                begin errors++; $display("FAIL reset_read r%0d got %h/%h busy %b exp 0", i, rd1_a, rd2_b, rb1_a); end
        end
        rst_n = 1'b1; idle(); tick();
        for (int i = 1; i < NR; i++) begin
            raddr_1 = AW'(i); raddr_2 = AW'(i); #1;
            checks++; if (rd1_a !== 32'h0 || rd2_a !== 32'h0 || rd1_b !== 32'h0)
                begin errors++; $display("FAIL post_reset_read r%0d got %h exp 0", i, rd1_a); end
        end
    endtask

    task automatic test_bypass();
        idle(); we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; raddr_1 = 5'd5; #1;
        checks++; if (rd1_a !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass1 got %h exp deadbeef", rd1_a); end
        checks++; if (rd1_b !== 32'h0) begin errors++; $display("FAIL bypass0_same got %h exp 0", rd1_b); end
        tick(); we = 1'b0; #1;
        checks++; if (rd1_b !== 32'hDEADBEEF) begin errors++; $display("FAIL bypass0_next got %h exp deadbeef", rd1_b); end
    endtask

    task automatic test_zero();
        idle(); we = 1'b1; waddr = 5'd0; wdata = 32'h12345678; raddr_1 = 5'd0; #1;
        checks++; if (rd1_a !== 32'h0) begin errors++; $display("FAIL r0_bypass got %h exp 0", rd1_a); end
        tick(); we = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd0; #1;
        checks++; if (rd1_b !== 32'h0) begin errors++; $display("FAIL r0_read got %h exp 0", rd1_b); end
        checks++; if (ok_a !== 1'b1) begin errors++; $display("FAIL r0_rsv_ok got %b exp 1", ok_a); end
        tick(); rsv_en = 1'b0; #1;
        checks++; if (cnt_a !== 6'd0) begin errors++; $display("FAIL r0_cnt got %0d exp 0", cnt_a); end
    endtask

    task automatic test_reserve_r7();
        idle(); rsv_en = 1'b1; rsv_addr = 5'd7; raddr_1 = 5'd7; #1; tick(); #1;
        checks++; if (ok_a !== 1'b0 || ok_b !== 1'b0) begin errors++; $display("FAIL r7_refuse got %b exp 0", ok_a); end
        checks++; if (rb1_a !== 1'b1 || cnt_a !== 6'd1) begin errors++; $display("FAIL r7_busy got %b cnt %0d exp 1/1", rb1_a, cnt_a); end
        tick(); we = 1'b1; waddr = 5'd7; wdata = 32'hCAFE0007; #1;
        checks++; if (ok_a !== 1'b1) begin errors++; $display("FAIL r7_rerelease_ok got %b exp 1", ok_a); end
        tick(); idle(); raddr_1 = 5'd7; #1;
        checks++; if (rb1_a !== 1'b1 || cnt_a !== 6'd1 || rd1_a !== 32'hCAFE0007)
            begin errors++; $display("FAIL r7_after got busy %b cnt %0d data %h exp 1/1/cafe0007", rb1_a, cnt_a, rd1_a); end
    endtask

    task automatic test_fill_flush();
        idle();
        for (int i = 1; i < NR; i++) begin
            rsv_en = 1'b1; rsv_addr = AW'(i); #1; tick();
        end
        rsv_en = 1'b0; #1;
        checks++; if (cnt_a !== 6'd31 || cnt_b !== 6'd31) begin errors++; $display("FAIL fill_cnt got %0d exp 31", cnt_a); end
        flush = 1'b1; rsv_en = 1'b1; rsv_addr = 5'd3; #1;
        checks++; if (ok_a !== 1'b0) begin errors++; $display("FAIL flush_rsv_ok got %b exp 0", ok_a); end
        tick(); idle(); #1;
        checks++; if (cnt_a !== 6'd0) begin errors++; $display("FAIL flush_cnt got %0d exp 0", cnt_a); end
        for (int i = 1; i < NR; i++) begin
            raddr_2 = AW'(i); #1;
            checks++; if (rb2_a !== 1'b0) begin errors++; $display("FAIL flush_busy r%0d got %b exp 0", i, rb2_a); end
        end
    endtask

    task automatic test_counter();
        idle(); rsv_en = 1'b1; rsv_addr = 5'd9; #1; tick();
        rsv_addr = 5'd2; we = 1'b1; waddr = 5'd9; wdata = 32'h9; #1; tick();
        idle(); raddr_1 = 5'd9; raddr_2 = 5'd2; #1;
        checks++; if (cnt_a !== 6'd1) begin errors++; $display("FAIL swap_cnt got %0d exp 1", cnt_a); end
        checks++; if (rb1_a !== 1'b0 || rb2_a !== 1'b1) begin errors++; $display("FAIL swap_busy got %b%b exp 01", rb1_a, rb2_a); end
        we = 1'b1; waddr = 5'd4; wdata = 32'h4; #1; tick(); idle(); #1;
        checks++; if (cnt_a !== 6'd1) begin errors++; $display("FAIL free_write_cnt got %0d exp 1", cnt_a); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            we = ($urandom_range(0, 1) == 1); waddr = AW'($urandom_range(0, NR-1)); wdata = $urandom();
            rsv_en = ($urandom_range(0, 9) < 7); rsv_addr = AW'($urandom_range(0, NR-1));
            flush = ($urandom_range(0, 39) == 0);
            raddr_1 = ($urandom_range(0, 3) == 0) ? waddr : AW'($urandom_range(0, NR-1));
            raddr_2 = ($urandom_range(0, 3) == 0) ? rsv_addr : AW'($urandom_range(0, NR-1));
            #1;
            checks++; if (rd1_a !== exp_rdata(raddr_1, 1'b1)) begin errors++; $display("FAIL rnd_rd1_a got %h exp %h", rd1_a, exp_rdata(raddr_1, 1'b1)); end
            checks++; if (rd2_a !== exp_rdata(raddr_2, 1'b1)) begin errors++; $display("FAIL rnd_rd2_a got %h exp %h", rd2_a, exp_rdata(raddr_2, 1'b1)); end
            checks++; if (rd1_b !== exp_rdata(raddr_1, 1'b0)) begin errors++; $display("FAIL rnd_rd1_b got %h exp %h", rd1_b, exp_rdata(raddr_1, 1'b0)); end
            checks++; if (rd2_b !== exp_rdata(raddr_2, 1'b0)) begin errors++; $display("FAIL rnd_rd2_b got %h exp %h", rd2_b, exp_rdata(raddr_2, 1'b0)); end
            checks++; if (rb1_a !== exp_rbusy(raddr_1) || rb1_b !== exp_rbusy(raddr_1)) begin errors++; $display("FAIL rnd_rbusy1 got %b%b exp %b", rb1_a, rb1_b, exp_rbusy(raddr_1)); end
            checks++; if (rb2_a !== exp_rbusy(raddr_2) || rb2_b !== exp_rbusy(raddr_2)) begin errors++; $display("FAIL rnd_rbusy2 got %b%b exp %b", rb2_a, rb2_b, exp_rbusy(raddr_2)); end
            checks++; if (ok_a !== exp_ok() || ok_b !== exp_ok()) begin errors++; $display("FAIL rnd_rsv_ok got %b%b exp %b", ok_a, ok_b, exp_ok()); end
            checks++; if (cnt_a !== exp_cnt() || cnt_b !== exp_cnt()) begin errors++; $display("FAIL rnd_cnt got %0d/%0d exp %0d", cnt_a, cnt_b, exp_cnt()); end
            tick();
        end
    endtask

    initial begin
        rst_n = 1'b0; idle(); model_clear();
        repeat (2) @(posedge clk);
        #2; rst_n = 1'b1; #1;
        test_reset();
        test_bypass();
        test_zero();
        test_reserve_r7();
        test_fill_flush();
        test_counter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
